md_unit: RTL and testbench

//  Multiply/divide responder for the pipelined MIPS core. Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request

---
 rtl/md_unit_pkg.sv | 24 ++
 rtl/md_unit.sv | 114 +++++++++++
 tb/tb_md_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and op classification helpers.
package md_unit_pkg;

    // Encodings of the md-class requests issued from the E stage; 6 and 7 are reserved.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    // Multi-cycle ops occupy the unit and raise busy; MTHI/MTLO complete in one edge.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op <= 3'd3);
    endfunction

    // Divides skip the HI/LO write when the divisor is zero.
    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide responder: latches one MULT/MULTU/DIV/DIVU request, models its latency with a
// down-counter and commits the result to HI/LO on the edge the counter reaches zero.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [CW-1:0]      counter;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    md_op_e             op_q;

    logic [2*WIDTH-1:0] prod_u;
    logic [2*WIDTH-1:0] prod_s;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   div_den;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               commit_en;

    // Products from the latched operands; sign-extending to 2*WIDTH makes the low 2*WIDTH bits the signed product.
    always_comb begin
        prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end

    // Division on magnitudes, then sign fix-up: quotient truncates toward zero, remainder follows the dividend.
    // The most negative value divided by -1 falls out naturally as a wrapped quotient with zero remainder,
    // and a zero divisor is replaced by one so the divider never sees it (the result is discarded anyway).
    always_comb begin
        a_neg   = (op_q == MD_DIV) && a_q[WIDTH-1];
        b_neg   = (op_q == MD_DIV) && b_q[WIDTH-1];
        a_mag   = a_neg ? (~a_q + 1'b1) : a_q;
        b_mag   = b_neg ? (~b_q + 1'b1) : b_q;
        div_den = (b_mag == '0) ? WIDTH'(1) : b_mag;
        q_mag   = a_mag / div_den;
        r_mag   = a_mag % div_den;
        quot    = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
        rem     = a_neg ? (~r_mag + 1'b1) : r_mag;
    end

    // Select the HI/LO pair for the op in flight and suppress the write for divide-by-zero.
    always_comb begin
        res_hi    = hi;
        res_lo    = lo;
        commit_en = !(is_div_op(op_q) && (b_q == '0));
        case (op_q)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV, MD_DIVU: begin
                res_hi = rem;
                res_lo = quot;
            end
            default: ;
        endcase
    end

    // Counter, operand latches, busy flag and HI/LO; requests are only looked at while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            busy    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= MD_MULT;
            hi      <= '0;
            lo      <= '0;
        end else if (counter != '0) begin
            counter <= counter - 1'b1;
            if (counter == CW'(1)) begin
                busy <= 1'b0;
                if (commit_en) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
        end else if (start) begin
            if (is_long_op(op)) begin
                a_q     <= a;
                b_q     <= b;
                op_q    <= md_op_e'(op);
                busy    <= 1'b1;
                counter <= is_div_op(md_op_e'(op)) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (op == MD_MTHI) begin
                hi <= a;
            end else if (op == MD_MTLO) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a time-based reference model predicts HI/LO/busy every cycle,
// and directed scenarios pin both the model and the DUT to hand-computed values.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks_total;
    int checks_passed;
    bit check_en;

    // Reference model state: result of an accepted op is computed up front and lands at commit_edge.
    int          edge_num;
    bit          m_pend;
    int          m_commit_edge;
    bit          m_pend_write;
    logic [31:0] m_pend_hi;
    logic [31:0] m_pend_lo;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Advance the model by one edge given the inputs the DUT saw at that edge.
    task automatic modelStep(input logic rst, input logic st, input logic [2:0] o,
                             input logic [31:0] aa, input logic [31:0] bb);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        edge_num++;
        if (rst) begin
            m_pend = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (m_pend) begin
            if (edge_num == m_commit_edge) begin
                m_pend = 1'b0;
                if (m_pend_write) begin
                    m_hi = m_pend_hi;
                    m_lo = m_pend_lo;
                end
            end
        end else if (st) begin
            sa = longint'($signed(aa));
            sb = longint'($signed(bb));
            ua = {32'd0, aa};
            ub = {32'd0, bb};
            m_pend_write = 1'b1;
            case (o)
                3'd0: begin
                    sp = sa * sb;
                    {m_pend_hi, m_pend_lo} = sp;
                end
                3'd1: begin
                    up = ua * ub;
                    {m_pend_hi, m_pend_lo} = up;
                end
                3'd2: begin
                    if (bb == 0) begin
                        m_pend_write = 1'b0;
                    end else begin
                        sq = sa / sb;
                        sr = sa % sb;
                        m_pend_lo = sq[31:0];
                        m_pend_hi = sr[31:0];
                    end
                end
                3'd3: begin
                    if (bb == 0) begin
                        m_pend_write = 1'b0;
                    end else begin
                        m_pend_lo = 32'(ua / ub);
                        m_pend_hi = 32'(ua % ub);
                    end
                end
                3'd4: m_hi = aa;
                3'd5: m_lo = aa;
                default: ;
            endcase
            if (o <= 3'd3) begin
                m_pend        = 1'b1;
                m_commit_edge = edge_num + ((o >= 3'd2) ? 10 : 5);
            end
        end
    endtask

    // Drive one cycle of inputs, let the DUT take the edge, then update the model.
    task automatic applyStimulus(input logic rst, input logic st, input logic [2:0] o,
                                 input logic [31:0] aa, input logic [31:0] bb);
        reset = rst;
        start = st;
        op    = o;
        a     = aa;
        b     = bb;
        @(posedge clk);
        modelStep(rst, st, o, aa, bb);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, $urandom, $urandom);
        end
    endtask

    // Compare the DUT against the model on every cycle once reset has been applied.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cycle busy", {31'd0, busy}, {31'd0, m_pend});
            checkOutput("cycle hi", hi, m_hi);
            checkOutput("cycle lo", lo, m_lo);
        end
    end

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        check_en      = 1'b0;
        edge_num      = 0;
        m_pend        = 1'b0;
        m_commit_edge = 0;
        m_pend_write  = 1'b0;
        m_pend_hi     = '0;
        m_pend_lo     = '0;
        m_hi          = '0;
        m_lo          = '0;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;

        applyStimulus(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        check_en = 1'b1;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);

        // MULT -2 * 3
        applyStimulus(1'b0, 1'b1, 3'd0, 32'hFFFFFFFE, 32'd3);
        checkOutput("mult busy rises", {31'd0, busy}, 32'd1);
        idle(4);
        checkOutput("mult busy last", {31'd0, busy}, 32'd1);
        idle(1);
        checkOutput("mult busy falls", {31'd0, busy}, 32'd0);
        checkOutput("mult hi", hi, 32'hFFFFFFFF);
        checkOutput("mult lo", lo, 32'hFFFFFFFA);
        checkOutput("model mult lo", m_lo, 32'hFFFFFFFA);

        // MULTU 0xFFFFFFFF * 2
        applyStimulus(1'b0, 1'b1, 3'd1, 32'hFFFFFFFF, 32'd2);
        idle(5);
        checkOutput("multu hi", hi, 32'h00000001);
        checkOutput("multu lo", lo, 32'hFFFFFFFE);

        // DIV -7 / 2, then DIVU 7 / 2
        applyStimulus(1'b0, 1'b1, 3'd2, 32'hFFFFFFF9, 32'd2);
        idle(9);
        checkOutput("div busy last", {31'd0, busy}, 32'd1);
        idle(1);
        checkOutput("div lo", lo, 32'hFFFFFFFD);
        checkOutput("div hi", hi, 32'hFFFFFFFF);
        checkOutput("model div hi", m_hi, 32'hFFFFFFFF);
        applyStimulus(1'b0, 1'b1, 3'd3, 32'd7, 32'd2);
        idle(10);
        checkOutput("divu lo", lo, 32'd3);
        checkOutput("divu hi", hi, 32'd1);

        // MTHI then MTLO, then divide by zero leaves them alone
        applyStimulus(1'b0, 1'b1, 3'd4, 32'h12345678, 32'd0);
        checkOutput("mthi hi", hi, 32'h12345678);
        checkOutput("mthi busy", {31'd0, busy}, 32'd0);
        checkOutput("mthi lo kept", lo, 32'd3);
        applyStimulus(1'b0, 1'b1, 3'd5, 32'h9ABCDEF0, 32'd0);
        checkOutput("mtlo lo", lo, 32'h9ABCDEF0);
        checkOutput("mtlo hi kept", hi, 32'h12345678);
        applyStimulus(1'b0, 1'b1, 3'd2, 32'd55, 32'd0);
        idle(9);
        checkOutput("div0 busy last", {31'd0, busy}, 32'd1);
        idle(1);
        checkOutput("div0 busy falls", {31'd0, busy}, 32'd0);
        checkOutput("div0 hi", hi, 32'h12345678);
        checkOutput("div0 lo", lo, 32'h9ABCDEF0);

        // Reserved op does nothing
        applyStimulus(1'b0, 1'b1, 3'd6, 32'hDEADBEEF, 32'd1);
        checkOutput("reserved busy", {31'd0, busy}, 32'd0);
        checkOutput("reserved hi", hi, 32'h12345678);

        // MULT with a DIVU request while busy, then DIVU back-to-back
        applyStimulus(1'b0, 1'b1, 3'd0, 32'd3, 32'd4);
        idle(2);
        applyStimulus(1'b0, 1'b1, 3'd3, 32'd1000, 32'd9);
        idle(2);
        checkOutput("ignored busy", {31'd0, busy}, 32'd0);
        checkOutput("ignored hi", hi, 32'd0);
        checkOutput("ignored lo", lo, 32'd12);
        applyStimulus(1'b0, 1'b1, 3'd3, 32'd100, 32'd7);
        checkOutput("b2b busy", {31'd0, busy}, 32'd1);
        idle(10);
        checkOutput("b2b lo", lo, 32'd14);
        checkOutput("b2b hi", hi, 32'd2);

        // Most negative value divided by -1 wraps
        applyStimulus(1'b0, 1'b1, 3'd2, 32'h80000000, 32'hFFFFFFFF);
        idle(10);
        checkOutput("ovf lo", lo, 32'h80000000);
        checkOutput("ovf hi", hi, 32'd0);

        // Negative divisor: -7 / -2 -> q=3, r=-1
        applyStimulus(1'b0, 1'b1, 3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE);
        idle(10);
        checkOutput("negdiv lo", lo, 32'd3);
        checkOutput("negdiv hi", hi, 32'hFFFFFFFF);

        // Reset aborts an in-flight DIV with no late commit
        applyStimulus(1'b0, 1'b1, 3'd2, 32'd50, 32'd5);
        idle(3);
        applyStimulus(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort hi", hi, 32'd0);
        checkOutput("abort lo", lo, 32'd0);
        idle(12);
        checkOutput("no late lo", lo, 32'd0);
        checkOutput("no late busy", {31'd0, busy}, 32'd0);

        check_en = 1'b0;
        @(posedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
